// File: rtl/shape_draw_seq.sv
// rtl/shape_draw_seq.sv - clear-then-draw sequencer feeding a line drawer into a framebuffer
module shape_draw_seq #(
    parameter int XY_BITW       = 10,
    parameter int LINE_CNT      = 12,
    parameter int LINEW         = $clog2(LINE_CNT),
    parameter int COLORW        = 3,
    parameter int FB_WIDTH      = 16,
    parameter int FB_HEIGHT     = 16,
    parameter int CLEAR_EN      = 1,
    parameter int CLEAR_COLOR   = 0,
    parameter int REDRAW_FRAMES = 0
) (
    input  logic               clk_pix,
    input  logic               rst,
    input  logic               en,
    input  logic               frame,
    input  logic [XY_BITW-1:0] sx,
    input  logic [XY_BITW-1:0] sy,
    output logic [LINEW-1:0]   line_id,
    input  logic [COLORW-1:0]  line_color,
    output logic               dl_start,
    output logic               dl_oe,
    input  logic [XY_BITW-1:0] dl_x,
    input  logic [XY_BITW-1:0] dl_y,
    input  logic               dl_drawing,
    input  logic               dl_done,
    output logic               fb_we,
    output logic [XY_BITW-1:0] fb_x,
    output logic [XY_BITW-1:0] fb_y,
    output logic [COLORW-1:0]  fb_color,
    output logic               fb_oe,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_START, S_DRAW, S_DONE
    } state_t;

    localparam int FCW = (REDRAW_FRAMES > 0) ? $clog2(REDRAW_FRAMES + 1) : 1;
    localparam logic [XY_BITW-1:0] CX_LAST   = XY_BITW'(FB_WIDTH - 1);
    localparam logic [XY_BITW-1:0] CY_LAST   = XY_BITW'(FB_HEIGHT - 1);
    localparam logic [LINEW-1:0]   LINE_LAST = LINEW'(LINE_CNT - 1);
    localparam logic [FCW-1:0]     FRM_LAST  = FCW'(REDRAW_FRAMES - 1);
    localparam logic               REDRAW_ON = (REDRAW_FRAMES > 0);

    state_t              r_state;
    state_t              w_state_nxt;
    state_t              w_pass_st;
    logic [XY_BITW-1:0]  r_cx;
    logic [XY_BITW-1:0]  r_cy;
    logic [LINEW-1:0]    r_line_id;
    logic [FCW-1:0]      r_frm_cnt;
    logic [COLORW-1:0]   r_fb_color;
    logic                r_dl_start;
    logic                r_dl_oe;
    logic                r_fb_oe;
    logic                r_busy;
    logic                w_frame_go;
    logic                w_redraw;
    logic                w_fb_we;
    logic [XY_BITW-1:0]  w_fb_x;
    logic [XY_BITW-1:0]  w_fb_y;

    assign w_pass_st  = (CLEAR_EN != 0) ? S_CLEAR : S_FETCH;
    assign w_frame_go = frame && en;
    // Redraw fires on the pulse that would bring the count up to REDRAW_FRAMES.
    assign w_redraw   = REDRAW_ON && w_frame_go && (r_frm_cnt == FRM_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_frame_go) w_state_nxt = w_pass_st;
            S_CLEAR: if (r_cx == CX_LAST && r_cy == CY_LAST) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_START;
            S_START: w_state_nxt = S_DRAW;
            S_DRAW:  if (dl_done) w_state_nxt = (r_line_id == LINE_LAST) ? S_DONE : S_FETCH;
            S_DONE:  if (w_redraw) w_state_nxt = w_pass_st;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cx       <= '0;
            r_cy       <= '0;
            r_line_id  <= '0;
            r_frm_cnt  <= '0;
            r_fb_color <= '0;
            r_dl_start <= 1'b0;
            r_dl_oe    <= 1'b0;
            r_fb_oe    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dl_start <= (w_state_nxt == S_START);
            r_dl_oe    <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_START) ||
                          (w_state_nxt == S_DRAW);
            r_busy     <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_FETCH) ||
                          (w_state_nxt == S_START) || (w_state_nxt == S_DRAW);
            r_fb_oe    <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_frame_go) r_line_id <= '0;
                end
                S_CLEAR: begin
                    if (r_cx == CX_LAST) begin
                        r_cx <= '0;
                        r_cy <= (r_cy == CY_LAST) ? '0 : r_cy + XY_BITW'(1);
                    end else begin
                        r_cx <= r_cx + XY_BITW'(1);
                    end
                end
                S_START: r_fb_color <= line_color;
                S_DRAW: begin
                    if (dl_done && r_line_id != LINE_LAST) r_line_id <= r_line_id + LINEW'(1);
                end
                S_DONE: begin
                    if (REDRAW_ON && w_frame_go) begin
                        if (r_frm_cnt == FRM_LAST) begin
                            r_frm_cnt <= '0;
                            r_line_id <= '0;
                        end else begin
                            r_frm_cnt <= r_frm_cnt + FCW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Framebuffer port is steered straight from the active source so drawer pixels land without delay.
    always_comb begin
        w_fb_we = 1'b0;
        w_fb_x  = '0;
        w_fb_y  = '0;
        case (r_state)
            S_CLEAR: begin
                w_fb_we = 1'b1;
                w_fb_x  = r_cx;
                w_fb_y  = r_cy;
            end
            S_DRAW: begin
                w_fb_we = dl_drawing;
                w_fb_x  = dl_x;
                w_fb_y  = dl_y;
            end
            S_DONE: begin
                w_fb_x = sx;
                w_fb_y = sy;
            end
            default: ;
        endcase
    end

    assign line_id  = r_line_id;
    assign dl_start = r_dl_start;
    assign dl_oe    = r_dl_oe;
    assign fb_oe    = r_fb_oe;
    assign busy     = r_busy;
    assign fb_we    = w_fb_we;
    assign fb_x     = w_fb_x;
    assign fb_y     = w_fb_y;
    assign fb_color = (r_state == S_CLEAR) ? COLORW'(CLEAR_COLOR) : r_fb_color;

endmodule

// File: tb/tb_shape_draw_seq.sv
// tb/tb_shape_draw_seq.sv - directed bench for shape_draw_seq (redraw and no-clear variants)
module tb_shape_draw_seq;

    logic       clk_pix = 1'b0;
    logic       rst = 1'b0, en = 1'b0, frame = 1'b0;
    logic [9:0] sx = '0, sy = '0, dl_x = '0, dl_y = '0;
    logic [2:0] line_color = '0;
    logic       dl_drawing = 1'b0, dl_done = 1'b0;
    logic [1:0] line_id;
    logic       dl_start, dl_oe, fb_we, fb_oe, busy;
    logic [9:0] fb_x, fb_y;
    logic [2:0] fb_color;

    logic       b_rst = 1'b0, b_en = 1'b0, b_frame = 1'b0;
    logic       b_dl_drawing = 1'b0, b_dl_done = 1'b0;
    logic [1:0] b_line_id;
    logic       b_dl_start, b_dl_oe, b_fb_we, b_fb_oe, b_busy;
    logic [9:0] b_fb_x, b_fb_y;
    logic [2:0] b_fb_color;

    int checks = 0;
    int errors = 0;
    int n_start = 0;
    logic [2:0] colors [3] = '{3'd5, 3'd2, 3'd7};

    always #5 clk_pix = ~clk_pix;
    always @(negedge clk_pix) if (dl_start) n_start++;

    shape_draw_seq #(.XY_BITW(10), .LINE_CNT(3), .COLORW(3), .FB_WIDTH(4), .FB_HEIGHT(4),
                     .CLEAR_EN(1), .CLEAR_COLOR(0), .REDRAW_FRAMES(2)) u_dut (
        .clk_pix(clk_pix), .rst(rst), .en(en), .frame(frame), .sx(sx), .sy(sy),
        .line_id(line_id), .line_color(line_color), .dl_start(dl_start), .dl_oe(dl_oe),
        .dl_x(dl_x), .dl_y(dl_y), .dl_drawing(dl_drawing), .dl_done(dl_done),
        .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_oe(fb_oe), .busy(busy)
    );

    shape_draw_seq #(.XY_BITW(10), .LINE_CNT(3), .COLORW(3), .FB_WIDTH(4), .FB_HEIGHT(4),
                     .CLEAR_EN(0), .CLEAR_COLOR(0), .REDRAW_FRAMES(0)) u_dut_nc (
        .clk_pix(clk_pix), .rst(b_rst), .en(b_en), .frame(b_frame), .sx(sx), .sy(sy),
        .line_id(b_line_id), .line_color(line_color), .dl_start(b_dl_start), .dl_oe(b_dl_oe),
        .dl_x(dl_x), .dl_y(dl_y), .dl_drawing(b_dl_drawing), .dl_done(b_dl_done),
        .fb_we(b_fb_we), .fb_x(b_fb_x), .fb_y(b_fb_y), .fb_color(b_fb_color), .fb_oe(b_fb_oe),
        .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if ({line_id, dl_start, dl_oe, fb_we, fb_oe, busy} !== 7'd0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0", {line_id, dl_start, dl_oe, fb_we, fb_oe, busy}); end
        checks++; if ({fb_x, fb_y, fb_color} !== 23'd0) begin
            errors++; $display("FAIL reset_fb got %0d/%0d/%0d want 0/0/0", fb_x, fb_y, fb_color); end
        tick(); rst = 1'b1;
        frame = 1'b1; tick(); frame = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_en0 busy got %b want 0", busy); end
    endtask

    task automatic test_clear();
        n_start = 0;
        en = 1'b1; frame = 1'b1; tick(); frame = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++; if (fb_we !== 1'b1 || fb_x !== 10'(i % 4) || fb_y !== 10'(i / 4) || fb_color !== 3'd0 || busy !== 1'b1) begin
                errors++; $display("FAIL clear_px%0d got we=%b x=%0d y=%0d c=%0d busy=%b want we=1 x=%0d y=%0d c=0 busy=1",
                                   i, fb_we, fb_x, fb_y, fb_color, busy, i % 4, i / 4); end
            tick();
        end
        checks++; if (dl_oe !== 1'b1 || busy !== 1'b1 || line_id !== 2'd0 || dl_start !== 1'b0) begin
            errors++; $display("FAIL fetch_after_clear got oe=%b busy=%b id=%0d st=%b want 1/1/0/0", dl_oe, busy, line_id, dl_start); end
        dl_drawing = 1'b1; dl_x = 10'd3; #1;
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL spurious_fetch_we got %b want 0", fb_we); end
        dl_drawing = 1'b0; dl_x = '0;
    endtask

    task automatic test_lines();
        for (int l = 0; l < 3; l++) begin
            line_color = colors[l];
            checks++; if (line_id !== 2'(l)) begin errors++; $display("FAIL fetch_id got %0d want %0d", line_id, l); end
            tick();
            checks++; if (dl_start !== 1'b1 || dl_oe !== 1'b1) begin
                errors++; $display("FAIL start_pulse line%0d got st=%b oe=%b want 1/1", l, dl_start, dl_oe); end
            tick();
            checks++; if (fb_color !== colors[l] || dl_start !== 1'b0) begin
                errors++; $display("FAIL draw_color line%0d got c=%0d st=%b want c=%0d st=0", l, fb_color, dl_start, colors[l]); end
            for (int k = 0; k < 5; k++) begin
                dl_drawing = 1'b1; dl_x = 10'(k); dl_y = 10'(l); dl_done = (k == 4);
                frame = (l == 1 && k == 4);
                #1;
                checks++; if (fb_we !== 1'b1 || fb_x !== 10'(k) || fb_y !== 10'(l)) begin
                    errors++; $display("FAIL draw_px l%0d k%0d got we=%b x=%0d y=%0d want 1/%0d/%0d", l, k, fb_we, fb_x, fb_y, k, l); end
                tick();
            end
            dl_drawing = 1'b0; dl_done = 1'b0; frame = 1'b0;
        end
        checks++; if (fb_oe !== 1'b1 || busy !== 1'b0 || dl_oe !== 1'b0) begin
            errors++; $display("FAIL done_state got oe=%b busy=%b dloe=%b want 1/0/0", fb_oe, busy, dl_oe); end
        checks++; if (n_start !== 3) begin errors++; $display("FAIL start_count got %0d want 3", n_start); end
        sx = 10'd7; sy = 10'd9; dl_drawing = 1'b1; #1;
        checks++; if (fb_x !== 10'd7 || fb_y !== 10'd9 || fb_we !== 1'b0) begin
            errors++; $display("FAIL done_readout got x=%0d y=%0d we=%b want 7/9/0", fb_x, fb_y, fb_we); end
        dl_drawing = 1'b0;
    endtask

    task automatic test_redraw();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame = 1'b1; tick(); frame = 1'b0; tick();
            checks++; if (fb_oe !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL hold_en0 pulse%0d got oe=%b busy=%b want 1/0", i, fb_oe, busy); end
        end
        en = 1'b1; frame = 1'b1; tick(); frame = 1'b0;
        checks++; if (fb_oe !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL first_pulse got oe=%b busy=%b want 1/0", fb_oe, busy); end
        tick(); frame = 1'b1; tick(); frame = 1'b0;
        checks++; if (busy !== 1'b1 || fb_we !== 1'b1 || fb_x !== 10'd0 || fb_y !== 10'd0 || line_id !== 2'd0 || fb_oe !== 1'b0) begin
            errors++; $display("FAIL redraw_clear got busy=%b we=%b x=%0d y=%0d id=%0d oe=%b want 1/1/0/0/0/0",
                               busy, fb_we, fb_x, fb_y, line_id, fb_oe); end
    endtask

    task automatic test_reset_mid();
        line_color = 3'd6;
        repeat (16) tick();
        checks++; if (dl_oe !== 1'b1) begin errors++; $display("FAIL redraw_fetch got %b want 1", dl_oe); end
        tick(); tick();
        dl_done = 1'b1; tick(); dl_done = 1'b0;
        tick(); tick();
        dl_drawing = 1'b1; dl_x = 10'd2; dl_y = 10'd1; #1;
        checks++; if (line_id !== 2'd1 || fb_we !== 1'b1 || fb_color !== 3'd6) begin
            errors++; $display("FAIL pre_reset got id=%0d we=%b c=%0d want 1/1/6", line_id, fb_we, fb_color); end
        #2 rst = 1'b0; #1;
        checks++; if ({line_id, dl_start, dl_oe, fb_we, fb_oe, busy} !== 7'd0 || {fb_x, fb_y, fb_color} !== 23'd0) begin
            errors++; $display("FAIL async_reset got ctrl=%b x=%0d y=%0d c=%0d want all 0",
                               {line_id, dl_start, dl_oe, fb_we, fb_oe, busy}, fb_x, fb_y, fb_color); end
        dl_drawing = 1'b0;
        tick(); rst = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || fb_we !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got busy=%b we=%b want 0/0", busy, fb_we); end
        en = 1'b0; frame = 1'b1; tick(); frame = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_en0 got %b want 0", busy); end
        en = 1'b1; frame = 1'b1; tick(); frame = 1'b0;
        checks++; if (busy !== 1'b1 || fb_we !== 1'b1) begin
            errors++; $display("FAIL post_reset_restart got busy=%b we=%b want 1/1", busy, fb_we); end
    endtask

    task automatic test_no_clear();
        b_rst = 1'b1; tick();
        b_en = 1'b1; b_frame = 1'b1; tick(); b_frame = 1'b0;
        checks++; if (b_dl_oe !== 1'b1 || b_fb_we !== 1'b0 || b_busy !== 1'b1 || b_line_id !== 2'd0) begin
            errors++; $display("FAIL nc_fetch got oe=%b we=%b busy=%b id=%0d want 1/0/1/0", b_dl_oe, b_fb_we, b_busy, b_line_id); end
        for (int l = 0; l < 3; l++) begin
            tick();
            checks++; if (b_dl_start !== 1'b1 || b_line_id !== 2'(l)) begin
                errors++; $display("FAIL nc_start l%0d got st=%b id=%0d want 1/%0d", l, b_dl_start, b_line_id, l); end
            tick();
            b_dl_done = 1'b1; tick(); b_dl_done = 1'b0;
        end
        checks++; if (b_fb_oe !== 1'b1) begin errors++; $display("FAIL nc_done got %b want 1", b_fb_oe); end
        for (int i = 0; i < 10; i++) begin
            b_frame = 1'b1; tick(); b_frame = 1'b0; tick();
            checks++; if (b_fb_oe !== 1'b1 || b_busy !== 1'b0) begin
                errors++; $display("FAIL nc_hold pulse%0d got oe=%b busy=%b want 1/0", i, b_fb_oe, b_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_lines();
        test_redraw();
        test_reset_mid();
        test_no_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shape_draw_seq.md
SHAPE_DRAW_SEQ -- requirements
Module: shape_draw_seq

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- XY_BITW, 10, coordinate width
- LINE_CNT, 12, lines per shape pass (>=1)
- LINEW, $clog2(LINE_CNT), line index width
- COLORW, 3, color width
- FB_WIDTH, 16, framebuffer width in pixels
- FB_HEIGHT, 16, framebuffer height in pixels
- CLEAR_EN, 1, run a clear sweep before each draw pass
- CLEAR_COLOR, 0, color written during clear
- REDRAW_FRAMES, 0, frames shown between redraws (0 = draw once, hold)

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_pix, in, 1, pixel clock; sole clock.
- rst, in, 1, asynchronous active-low reset.
- en, in, 1, permits starting a pass and counting frames.
- frame, in, 1, one-cycle frame-start pulse from display timing.
- sx / sy, in, XY_BITW each, current screen position.
- line_id, out, LINEW, index sent to the shape source.
- line_color, in, COLORW, shape source color, valid 1 cycle after line_id changes.
- dl_start, out, 1, line drawer start pulse.
- dl_oe, out, 1, line drawer enable.
- dl_x / dl_y, in, XY_BITW each, line drawer pixel.
- dl_drawing, in, 1, line drawer pixel valid.
- dl_done, in, 1, line drawer finished pulse.
- fb_we, out, 1, framebuffer write enable.
- fb_x / fb_y, out, XY_BITW each, framebuffer address.
- fb_color, out, COLORW, framebuffer write data.
- fb_oe, out, 1, framebuffer readout enable.
- busy, out, 1, a pass is in progress.

Function
REQ-003 The FSM SHALL have states IDLE, CLEAR, FETCH, START, DRAW, DONE, all registered on clk_pix.
REQ-004 IDLE SHALL go to CLEAR when frame=1 and en=1 and CLEAR_EN=1; it SHALL go to FETCH when CLEAR_EN=0 under the same condition; line_id SHALL be set to 0 on leaving IDLE.
REQ-005 CLEAR behaviour:
- Sweeps cx 0..FB_WIDTH-1 (inner loop) and cy 0..FB_HEIGHT-1 (outer loop), one pixel per cycle.
- fb_we=1, fb_color=CLEAR_COLOR, fb_x=cx, fb_y=cy.
- Goes to FETCH after pixel (FB_WIDTH-1, FB_HEIGHT-1).
- Lasts exactly FB_WIDTH*FB_HEIGHT cycles.
REQ-006 FETCH SHALL last exactly 1 cycle (shape source latency) and go to START.
REQ-007 START SHALL, for exactly 1 cycle:
- assert dl_start=1;
- latch line_color into fb_color;
- go to DRAW.
REQ-008 DRAW SHALL:
- set fb_we=dl_drawing, fb_x=dl_x, fb_y=dl_y;
- on dl_done=1 go to DONE if line_id==LINE_CNT-1;
- otherwise increment line_id and go to FETCH.
REQ-009 DONE SHALL set fb_oe=1, fb_x=sx, fb_y=sy and fb_we=0.
REQ-010 In DONE with REDRAW_FRAMES>0, each frame pulse with en=1 SHALL increment a frame counter; on the pulse where the counter reaches REDRAW_FRAMES, the counter SHALL clear, line_id SHALL go to 0, and the FSM SHALL enter CLEAR (or FETCH when CLEAR_EN=0).
REQ-011 With REDRAW_FRAMES=0, DONE SHALL be terminal until reset.
REQ-012 en=0 SHALL NOT abort a pass in progress; it SHALL only block the IDLE exit and freeze the DONE frame counter.
REQ-013 frame pulses in CLEAR, FETCH, START and DRAW SHALL be ignored and SHALL NOT be counted.
REQ-014 dl_done or dl_drawing outside DRAW SHALL be ignored (fb_we=0).
REQ-015 dl_oe SHALL be 1 exactly in FETCH, START and DRAW.
REQ-016 busy SHALL be 1 exactly in CLEAR, FETCH, START and DRAW.
REQ-017 In IDLE, fb_x and fb_y SHALL be 0.
REQ-018 The frame counter SHALL be $clog2(REDRAW_FRAMES+1) bits wide; the sweep counters SHALL be XY_BITW bits wide and never exceed FB_WIDTH-1 / FB_HEIGHT-1.

Reset
REQ-019 rst=0 SHALL immediately, regardless of clock, force:
- state=IDLE;
- line_id, cx, cy, frame counter and fb_color to 0;
- dl_start, dl_oe, fb_we, fb_oe and busy to 0;
- fb_x and fb_y to 0.
REQ-020 Reset mid-pass SHALL discard all progress; after release the block SHALL wait for the next frame pulse with en=1.

Verification
Test parameters: LINE_CNT=3, FB_WIDTH=4, FB_HEIGHT=4, CLEAR_EN=1, REDRAW_FRAMES=2.
REQ-021 Clear sweep: en=1, frame pulse -> 16 consecutive cycles of fb_we=1, fb_color=0, addresses (0,0),(1,0)..(3,3); then FETCH.
REQ-022 Line sequence: drawer returns dl_done 5 cycles after each start -> exactly 3 dl_start pulses with line_id 0,1,2, each 1 cycle after FETCH; fb_color equals line_color sampled at each START; then fb_oe=1.
REQ-023 Redraw: in DONE, 2 frame pulses -> CLEAR re-entered on the 2nd pulse with line_id=0; with en=0 any number of pulses -> remains DONE.
REQ-024 Ignored events: frame pulse coincident with dl_done in DRAW -> not counted; a spurious dl_drawing in FETCH -> fb_we stays 0.
REQ-025 Reset: rst=0 asserted mid-DRAW on line 1 -> outputs zero within the same cycle with no clock edge; after release, no activity until frame=1 with en=1.
REQ-026 CLEAR_EN=0, REDRAW_FRAMES=0 variant: frame -> FETCH directly (no writes); after the last line, DONE holds across 10 frame pulses.
